// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: control inputs and decoded rate/ISI outputs of the spike decoder
interface spike_rate_decoder_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
);
  logic             ena;
  logic             clear;
  logic             spike_in;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] rate_out;
  logic             rate_sat;
  logic             rate_valid;
  logic [ISI_W-1:0] isi_out;
  logic             isi_valid;
  modport master (
    output ena, clear, spike_in, window_len,
    input  rate_out, rate_sat, rate_valid, isi_out, isi_valid
  );
  modport slave (
    input  ena, clear, spike_in, window_len,
    output rate_out, rate_sat, rate_valid, isi_out, isi_valid
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: decodes a spike line into per-window spike counts and inter-spike intervals
module spike_rate_decoder #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  spike_rate_decoder_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;
  state_t           state;
  logic             spike_d;
  logic [CNT_W-1:0] count;
  logic             sat_q;
  logic [WIN_W-1:0] wcnt;
  logic [WIN_W-1:0] len_q;
  logic [ISI_W-1:0] isi_timer;
  logic             have_prev;
  logic [CNT_W-1:0] rate_q;
  logic             rate_sat_q;
  logic             rate_valid_q;
  logic [ISI_W-1:0] isi_q;
  logic             isi_valid_q;
  logic             spike_edge;
  logic             sat_hit;
  logic             last;
  logic [WIN_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_next;
  logic [ISI_W-1:0] isi_next;
  // the enabling cycle out of IDLE is window cycle 0, so it compares against the live window_len
  assign spike_edge = bus.spike_in & ~spike_d;
  assign len_eff    = (state == RUN) ? len_q : bus.window_len;
  assign last       = wcnt == len_eff;
  assign sat_hit    = spike_edge && count == CNT_MAX;
  assign cnt_next   = count + CNT_W'(spike_edge & ~sat_hit);
  assign isi_next   = (isi_timer == ISI_MAX) ? isi_timer : isi_timer + ISI_W'(1);
  assign bus.rate_out   = rate_q;
  assign bus.rate_sat   = rate_sat_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.isi_out    = isi_q;
  assign bus.isi_valid  = isi_valid_q;
  // state machine, window counter, rate and interval measurement with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      spike_d      <= 1'b0;
      count        <= '0;
      sat_q        <= 1'b0;
      wcnt         <= '0;
      len_q        <= '0;
      isi_timer    <= '0;
      have_prev    <= 1'b0;
      rate_q       <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      spike_d      <= bus.spike_in;
      rate_valid_q <= 1'b0;
      isi_valid_q  <= 1'b0;
      if (bus.clear) begin
        rate_q     <= '0;
        rate_sat_q <= 1'b0;
        isi_q      <= '0;
        count      <= '0;
        sat_q      <= 1'b0;
        isi_timer  <= '0;
        have_prev  <= 1'b0;
        wcnt       <= '0;
        len_q      <= bus.window_len;
      end else if (!bus.ena) begin
        state     <= IDLE;
        count     <= '0;
        sat_q     <= 1'b0;
        wcnt      <= '0;
        isi_timer <= '0;
        have_prev <= 1'b0;
      end else begin
        state <= RUN;
        if (last) begin
          rate_q       <= cnt_next;
          rate_sat_q   <= sat_q | sat_hit;
          rate_valid_q <= 1'b1;
          count        <= '0;
          sat_q        <= 1'b0;
          wcnt         <= '0;
          len_q        <= bus.window_len;
        end else begin
          count <= cnt_next;
          sat_q <= sat_q | sat_hit;
          wcnt  <= wcnt + WIN_W'(1);
          if (state == IDLE) len_q <= bus.window_len;
        end
        if (spike_edge) begin
          if (have_prev) begin
            isi_q       <= isi_timer;
            isi_valid_q <= 1'b1;
          end
          have_prev <= 1'b1;
          isi_timer <= ISI_W'(1);
        end else begin
          isi_timer <= isi_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed checks of rate and ISI decoding on 8-bit and 4-bit instances
module tb_spike_rate_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       clear = 1'b0;
  logic       spike = 1'b0;
  logic [7:0] wlen = 8'd0;
  int tests = 0;
  int fails = 0;
  spike_rate_decoder_if #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) b8 ();
  spike_rate_decoder_if #(.WIN_W(8), .CNT_W(4), .ISI_W(4)) b4 ();
  assign b8.ena = ena;
  assign b8.clear = clear;
  assign b8.spike_in = spike;
  assign b8.window_len = wlen;
  assign b4.ena = ena;
  assign b4.clear = clear;
  assign b4.spike_in = spike;
  assign b4.window_len = wlen;
  spike_rate_decoder #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  spike_rate_decoder #(.WIN_W(8), .CNT_W(4), .ISI_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic restart;
    ena = 1'b0;
    clear = 1'b0;
    spike = 1'b0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_rate", b8.rate_out, 0);
    chk("rst_sat", b8.rate_sat, 0);
    chk("rst_rv", b8.rate_valid, 0);
    chk("rst_isi", b8.isi_out, 0);
    chk("rst_iv", b8.isi_valid, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      spike = (c % 2 == 0);
      tick();
      chk("idle_rv", b8.rate_valid, 0);
      chk("idle_iv", b8.isi_valid, 0);
    end
    restart();
    wlen = 8'd9;
    ena = 1'b1;
    for (int c = 0; c < 20; c++) begin
      spike = (c % 10 == 0) || (c % 10 == 3) || (c % 10 == 6) || (c % 10 == 9);
      tick();
      chk("rate_rv", b8.rate_valid, (c % 10 == 9));
      if (c == 9) begin
        chk("rate_w1", b8.rate_out, 4);
        chk("rate_w1_sat", b8.rate_sat, 0);
      end
      if (c == 13) begin
        chk("rate_isi", b8.isi_out, 4);
        chk("rate_isi_v", b8.isi_valid, 1);
      end
      if (c == 19) chk("rate_w2_merged", b8.rate_out, 3);
    end
    restart();
    wlen = 8'd200;
    ena = 1'b1;
    for (int c = 0; c < 26; c++) begin
      spike = (c == 5) || (c >= 8 && c <= 11) || (c == 20);
      tick();
      chk("isi_v", b8.isi_valid, (c == 8) || (c == 20));
      if (c == 8) chk("isi_3", b8.isi_out, 3);
      if (c == 20) chk("isi_12", b8.isi_out, 12);
    end
    restart();
    wlen = 8'd39;
    ena = 1'b1;
    for (int c = 0; c < 40; c++) begin
      spike = (c % 2 == 0);
      tick();
    end
    chk("sat4_rv", b4.rate_valid, 1);
    chk("sat4_rate", b4.rate_out, 15);
    chk("sat4_flag", b4.rate_sat, 1);
    chk("sat8_rate", b8.rate_out, 20);
    chk("sat8_flag", b8.rate_sat, 0);
    restart();
    wlen = 8'd200;
    ena = 1'b1;
    for (int c = 0; c < 31; c++) begin
      spike = (c == 0) || (c == 30);
      tick();
    end
    chk("isisat4", b4.isi_out, 15);
    chk("isisat4_v", b4.isi_valid, 1);
    chk("isi8_30", b8.isi_out, 30);
    restart();
    wlen = 8'd4;
    ena = 1'b1;
    for (int c = 0; c < 10; c++) begin
      spike = (c == 4);
      tick();
      if (c == 4) begin
        chk("last_edge_rate", b8.rate_out, 1);
        chk("last_edge_rv", b8.rate_valid, 1);
      end
      if (c == 9) chk("next_win_rate", b8.rate_out, 0);
    end
    restart();
    wlen = 8'd5;
    ena = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) wlen = 8'd2;
      tick();
      chk("wlen_change_rv", b8.rate_valid, (c == 5) || (c == 8) || (c == 11));
    end
    restart();
    wlen = 8'd0;
    ena = 1'b1;
    for (int c = 0; c < 4; c++) begin
      spike = 1'b1;
      tick();
      chk("w0_rv", b8.rate_valid, 1);
      chk("w0_rate", b8.rate_out, (c == 0));
    end
    restart();
    wlen = 8'd9;
    ena = 1'b1;
    for (int c = 0; c < 14; c++) begin
      spike = (c == 1) || (c == 11);
      tick();
      if (c == 9) chk("drop_pre_rate", b8.rate_out, 1);
      if (c > 9) chk("drop_pre_rv", b8.rate_valid, 0);
    end
    ena = 1'b0;
    for (int k = 0; k < 6; k++) begin
      spike = (k % 2 == 1);
      tick();
      chk("drop_rv", b8.rate_valid, 0);
      chk("drop_hold", b8.rate_out, 1);
    end
    ena = 1'b1;
    for (int c = 0; c < 10; c++) begin
      spike = (c == 2);
      tick();
      chk("drop_restart_rv", b8.rate_valid, (c == 9));
      if (c == 9) chk("drop_restart_rate", b8.rate_out, 1);
    end
    restart();
    wlen = 8'd9;
    ena = 1'b1;
    for (int c = 0; c < 4; c++) begin
      spike = (c == 1) || (c == 3);
      clear = (c == 3);
      tick();
    end
    chk("clr_rate", b8.rate_out, 0);
    chk("clr_sat", b8.rate_sat, 0);
    chk("clr_isi", b8.isi_out, 0);
    clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      spike = (c == 5);
      tick();
      chk("clr_rv", b8.rate_valid, (c == 9));
      if (c == 5) chk("clr_iv", b8.isi_valid, 0);
      if (c == 9) chk("clr_rate_after", b8.rate_out, 1);
    end
    wlen = 8'd0;
    for (int c = 0; c < 3; c++) begin
      spike = (c % 2 == 0);
      tick();
    end
    chk("pre_arst_rate", b8.rate_out, 1);
    chk("pre_arst_isi", b8.isi_out, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rate", b8.rate_out, 0);
    chk("arst_rv", b8.rate_valid, 0);
    chk("arst_isi", b8.isi_out, 0);
    chk("arst_iv", b8.isi_valid, 0);
    chk("arst_sat", b4.rate_sat, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
